vga_write_arbiter: RTL
======================

VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 SHALL have parameter H_RES, default 320, meaning visible pixels per line.
REQ-002 SHALL have parameter V_RES, default 240, meaning visible lines per frame.
REQ-003 SHALL have parameter X_W, default 9, meaning x coordinate width.
REQ-004 SHALL have parameter Y_W, default 8, meaning y coordinate width.
REQ-005 SHALL have parameter C_W, default 24, meaning pixel colour width {r[7:0], g[7:0], b[7:0]}.
REQ-006 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- blank_only  in  1  when 1, new grants are issued only while vblank=1.
- vblank  in  1  vertical blanking indication from the VGA timing block.
- r0_valid, r1_valid  in  1 each  requester has a pixel write pending.
- r0_ready, r1_ready  out  1 each  request accepted this cycle.
- r0_x, r1_x  in  X_W each  pixel x coordinate.
- r0_y, r1_y  in  Y_W each  pixel y coordinate.
- r0_color, r1_color  in  C_W each  pixel colour.
- fb_we  out  1  frame-buffer write strobe.
- fb_x  out  X_W  write x coordinate.
- fb_y  out  Y_W  write y coordinate.
- fb_color  out  C_W  write colour.
- fb_wait  in  1  frame buffer stall; a write completes on a cycle with fb_we=1 and fb_wait=0.
- busy  out  1  1 while in state WRITE.
- oob_drop  out  1  one-cycle pulse when an out-of-range request is discarded.
- write_count  out  16  count of completed frame-buffer writes.

Function
REQ-007 SHALL implement FSM states IDLE and WRITE.
REQ-008 SHALL mark a requester eligible in IDLE when its valid=1 and (blank_only=0 or vblank=1).
REQ-009 SHALL grant in IDLE the eligible requester, using round-robin when both are eligible: the requester not granted last wins.
REQ-010 SHALL drive rN_ready=1 combinationally for the granted requester only, in IDLE only, and never to both in one cycle.
REQ-011 SHALL require a requester to hold valid and its payload stable until ready=1; the arbiter samples the payload on the ready cycle.
REQ-012 SHALL, on an in-range grant (x<H_RES and y<V_RES), register the payload into fb_x/fb_y/fb_color, update the last-grant pointer, and go to WRITE.
REQ-013 SHALL, on an out-of-range grant, accept it (ready=1), pulse oob_drop the next cycle, update the pointer, stay in IDLE, and not assert fb_we.
REQ-014 SHALL hold fb_we=1 and fb_x/fb_y/fb_color stable throughout WRITE.
REQ-015 SHALL, in WRITE with fb_wait=0, go to IDLE and increment write_count; fb_we is 0 on the following cycle.
REQ-016 SHALL stay in WRITE indefinitely while fb_wait=1, with no timeout.
REQ-017 SHALL complete a WRITE regardless of changes to vblank or blank_only after the grant.
REQ-018 SHALL have a latency of 1 cycle from acceptance to fb_we=1, and a throughput of at most one write per 2 cycles.
REQ-019 SHALL wrap write_count from 16'hFFFF to 0.
REQ-020 SHALL leave fb_x/fb_y/fb_color as don't-care while fb_we=0; they hold their last value.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, set state=IDLE, fb_we=0, fb_x=0, fb_y=0, fb_color=0, oob_drop=0, write_count=0, busy=0, and the last-grant pointer so requester 0 wins the first tie.
REQ-022 SHALL abandon an in-progress WRITE on reset, with fb_we=0 from the next cycle and no count increment.
REQ-023 SHALL hold r0_ready=r1_ready=0 while reset=1.

Structure
REQ-024 SHALL place H_RES/V_RES defaults, X_W/Y_W/C_W defaults and the FSM state enum in a shared package vga_pkg.
REQ-025 SHALL isolate the two-way round-robin picker in a sub-module rr_arb2 (inputs req[1:0], last; output gnt[1:0]; purely combinational).

Verification
REQ-026 SHALL test a single write: r0 sends x=5, y=7, color=24'hFF0000 with fb_wait=0 -> r0_ready for 1 cycle; next cycle fb_we=1, fb_x=5, fb_y=7; write_count=1.
REQ-027 SHALL test round-robin: both valid continuously for 4 grants after reset -> grant order r0, r1, r0, r1; write_count=4.
REQ-028 SHALL test a stall: fb_wait=1 for 5 cycles during WRITE -> fb_we and payload stable for 6 cycles, no new ready, count +1 only at completion.
REQ-029 SHALL test blank gating: blank_only=1, vblank=0, r1_valid=1 for 10 cycles -> no ready; vblank goes 1 -> r1_ready the same cycle.
REQ-030 SHALL test out-of-range: r0 sends x=320, y=0 -> r0_ready=1, oob_drop pulse, fb_we stays 0, write_count unchanged.
REQ-031 SHALL test reset mid-WRITE: reset asserted with fb_wait=1 -> fb_we=0 and write_count=0 next cycle; first tie afterwards goes to r0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer write arbiter:
// resolution and field-width defaults plus the arbiter FSM encoding.
package vga_pkg;

  // Default visible resolution.
  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  // Default coordinate and colour widths; colour is {r[7:0], g[7:0], b[7:0]}.
  localparam int X_W_DEF = 9;
  localparam int Y_W_DEF = 8;
  localparam int C_W_DEF = 24;

  // Arbiter FSM: IDLE accepts one request, WRITE presents it to the frame buffer.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // Encoding of the last-grant pointer (index of the requester granted last).
  localparam logic LAST_R0 = 1'b0;
  localparam logic LAST_R1 = 1'b1;

endpackage : vga_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Purely combinational: when both requesters
// ask, the one that was not granted last wins; a lone requester always wins.
// The two grant bits are mutually exclusive by construction.
module rr_arb2
  import vga_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant requester 0 unless requester 1 also asks and requester 0 went last.
  always_comb begin
    gnt[0] = req[0] & (~req[1] | (last == LAST_R1));
    gnt[1] = req[1] & (~req[0] | (last == LAST_R0));
  end

endmodule : rr_arb2

// File: rtl/vga_write_arbiter.sv
// Arbitrates pixel writes from two requesters onto a single frame-buffer
// write port. A request is accepted in IDLE (ready pulses combinationally),
// its payload is registered, and the write is held in WRITE until the frame
// buffer stops stalling. Out-of-range pixels are accepted and discarded with
// a one-cycle oob_drop pulse. New grants can optionally be restricted to
// vertical blanking.
module vga_write_arbiter
  import vga_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int C_W   = C_W_DEF
) (
  input  logic           clk,
  input  logic           reset,

  input  logic           blank_only,
  input  logic           vblank,

  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic [X_W-1:0] r0_x,
  input  logic [Y_W-1:0] r0_y,
  input  logic [C_W-1:0] r0_color,

  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic [X_W-1:0] r1_x,
  input  logic [Y_W-1:0] r1_y,
  input  logic [C_W-1:0] r1_color,

  output logic           fb_we,
  output logic [X_W-1:0] fb_x,
  output logic [Y_W-1:0] fb_y,
  output logic [C_W-1:0] fb_color,
  input  logic           fb_wait,

  output logic           busy,
  output logic           oob_drop,
  output logic [15:0]    write_count
);

  // Range limits widened by one bit so a limit equal to 2**X_W still compares correctly.
  localparam logic [X_W:0] H_LIM = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0] V_LIM = (Y_W + 1)'(V_RES);

  state_e         state;
  logic           last;          // index of the requester granted most recently
  logic           grant_window;  // grants may be issued this cycle
  logic [1:0]     elig;
  logic [1:0]     gnt;
  logic           accept;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [C_W-1:0] sel_color;
  logic           in_range;

  // Grants only in IDLE, never during reset, and only in vblank when gated.
  always_comb begin
    grant_window = (state == IDLE) & ~reset & (~blank_only | vblank);
    elig         = {r1_valid, r0_valid} & {2{grant_window}};
  end

  rr_arb2 u_rr_arb2 (
    .req  (elig),
    .last (last),
    .gnt  (gnt)
  );

  // Route the granted requester's payload and classify it against the visible area.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default is how latches get inferred.
    sel_x     = r0_x;
    sel_y     = r0_y;
    sel_color = r0_color;
    if (gnt[1]) begin
      sel_x     = r1_x;
      sel_y     = r1_y;
      sel_color = r1_color;
    end
    accept   = |gnt;
    in_range = ({1'b0, sel_x} < H_LIM) && ({1'b0, sel_y} < V_LIM);
  end

  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];
  assign fb_we    = (state == WRITE);
  assign busy     = (state == WRITE);

  // FSM, last-grant pointer, drop pulse and completed-write counter.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      last        <= LAST_R1;  // requester 0 wins the first tie
      oob_drop    <= 1'b0;
      write_count <= '0;
    end else begin
      oob_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            last <= gnt[1];
            if (in_range) begin
              state <= WRITE;
            end else begin
              oob_drop <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Completion ignores vblank/blank_only; the stall has no timeout.
          if (!fb_wait) begin
            state       <= IDLE;
            write_count <= write_count + 16'd1;  // wraps naturally at 16'hFFFF
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame-buffer payload: captured on an in-range acceptance, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= '0;
    end else if (accept && in_range) begin
      fb_x     <= sel_x;
      fb_y     <= sel_y;
      fb_color <= sel_color;
    end
  end

endmodule : vga_write_arbiter
